// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported unified memory between the
//               instruction-fetch port (i_*) and the load/store port (d_*).
//               One transaction is outstanding at a time. Data accesses win
//               arbitration unless fetch has waited through STARVE_LIMIT
//               consecutive data grants, in which case fetch is forced.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_req/i_addr      fetch request, held until i_gnt
//   i_gnt             fetch request accepted this cycle
//   i_rvalid/i_rdata  fetch response pulse and instruction word
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                     load/store request and payload, held until d_gnt
//   d_gnt             data request accepted this cycle
//   d_rvalid/d_rdata  load data / store ack pulse and raw load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb
//                     request towards the memory
//   mem_gnt           memory accepts the request this cycle
//   mem_rvalid/mem_rdata
//                     memory response pulse and read data
//   busy              a transaction is outstanding
// Parameters
//   ADDR_W            address width of all ports
//   DATA_W            data width; only 32 is supported (4-bit strobes)
//   STARVE_LIMIT      data grants tolerated while fetch waits, 1..15
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic [3:0] r_starv_cnt;

  logic w_idle;
  logic w_starved;
  logic w_sel_d;
  logic w_sel_i;
  logic w_i_gnt;
  logic w_d_gnt;

  // The reset term keeps every output at zero while rst is held, even though
  // the state register already sits in IDLE during reset.
  assign w_idle    = !rst && (r_state == IDLE);

  // Fetch has waited long enough: it takes the next slot over data.
  assign w_starved = i_req && (r_starv_cnt == c_STARVE_LIMIT);
  assign w_sel_d   = w_idle && d_req && !w_starved;
  assign w_sel_i   = w_idle && i_req && !w_sel_d;

  assign w_d_gnt   = w_sel_d && mem_gnt;
  assign w_i_gnt   = w_sel_i && mem_gnt;

  // --------------------------------------------------------------------------
  // Request path towards memory
  // --------------------------------------------------------------------------
  assign mem_req   = w_idle && (i_req || d_req);
  assign mem_addr  = w_sel_d ? d_addr : (w_sel_i ? i_addr : '0);
  assign mem_we    = w_sel_d && d_we;
  assign mem_wdata = w_sel_d ? d_wdata : '0;
  assign mem_wstrb = (w_sel_d && d_we) ? d_wstrb : 4'b0000;

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;

  // --------------------------------------------------------------------------
  // Response path: routed straight through to the owner of the transaction
  // --------------------------------------------------------------------------
  assign i_rvalid  = !rst && (r_state == WAIT_I) && mem_rvalid;
  assign d_rvalid  = !rst && (r_state == WAIT_D) && mem_rvalid;
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  assign busy      = !rst && (r_state != IDLE);

  // --------------------------------------------------------------------------
  // Transaction FSM and starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_starv_cnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_gnt) begin
            r_state <= WAIT_D;
          end else if (w_i_gnt) begin
            r_state <= WAIT_I;
          end
        end
        WAIT_I, WAIT_D: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Counts data grants that bypassed a waiting fetch; any grant that
      // leaves fetch unblocked clears it.
      if (w_d_gnt) begin
        if (i_req) begin
          if (r_starv_cnt < c_STARVE_LIMIT) begin
            r_starv_cnt <= r_starv_cnt + 4'd1;
          end
        end else begin
          r_starv_cnt <= 4'd0;
        end
      end else if (w_i_gnt) begin
        r_starv_cnt <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store port of the RISC-V core.
- Sits between the core's PC/Instr and Mem_WrAddr/Mem_WrData/ReadData interfaces and the memory model.
- Keeps one transaction outstanding. Data accesses have priority, and a starvation guard ensures fetch still makes forward progress.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width. Must be 32; the strobe is 4 bits.
- STARVE_LIMIT, 4, number of consecutive data grants taken while fetch is pending before fetch is forced. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid; one-cycle pulse
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  load/store request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data, already lane-aligned
- d_wstrb  in  4  byte-lane enables for stores
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store acknowledged; one-cycle pulse
- d_rdata  out  DATA_W  load data, raw, before load extension
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response (read data or write ack); one cycle
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  a transaction is outstanding

Behaviour:
- FSM states: IDLE, WAIT_I, WAIT_D. Reset state is IDLE. The starvation counter starv_cnt resets to 0.
- While rst is high, all outputs are 0.
- In IDLE, arbitration is combinational:
  - sel_d = d_req && !(i_req && starv_cnt == STARVE_LIMIT).
  - sel_i = i_req && !sel_d.
- mem_req = IDLE && (i_req || d_req).
- mem_addr, mem_we, mem_wdata and mem_wstrb come from the selected port.
  - Fetch selected: mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
  - Load: mem_wstrb = 0.
  - Store: mem_wstrb = d_wstrb.
- Grants: i_gnt = sel_i && mem_gnt; d_gnt = sel_d && mem_gnt. Both are 0 outside IDLE. At most one grant per cycle.
- On a grant, move to WAIT_I or WAIT_D. Without mem_gnt, stay in IDLE and re-arbitrate next cycle. The selection may change if the inputs change.
- In WAIT_x, mem_req = 0.
  - On mem_rvalid, x_rvalid = 1 in the same cycle, with x_rdata = mem_rdata (combinational route), and the FSM returns to IDLE.
  - The non-owner's rvalid stays 0.
  - i_rdata and d_rdata are 0 when not valid.
- Throughput: at least 2 cycles per access (grant cycle plus response cycle). The next arbitration happens in the cycle after the response.
- busy = (state != IDLE).
- Starvation counter, updated on grants only:
  - d_gnt with i_req high: starv_cnt + 1, saturating at STARVE_LIMIT.
  - d_gnt with i_req low: cleared to 0.
  - i_gnt: cleared to 0.
- No timeout. WAIT_x waits indefinitely for mem_rvalid.
- mem_rvalid in IDLE is ignored; no rvalid is generated.
- Reset mid-transaction: FSM goes to IDLE and starv_cnt to 0. A late mem_rvalid is ignored.
- A requester dropping req before its grant is legal and causes no grant.

Test Plan:
- Single fetch, i_addr=0x100, mem_gnt=1, memory responds 1 cycle later with 0x00500093 -> i_gnt in cycle 0, i_rvalid=1 with i_rdata=0x00500093 in cycle 1, busy=1 only in cycle 1.
- i_req and d_req both asserted in IDLE, d_we=1, d_addr=0x200, d_wstrb=4'b0011 -> d_gnt first; mem_we=1, mem_wstrb=0011; i_gnt only after d_rvalid.
- i_req held high with d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; starv_cnt returns to 0 after each I grant.
- d_req (load) with mem_gnt low for 3 cycles -> mem_req high 3 cycles, no grant; d_gnt on the 4th cycle; d_rvalid only after mem_rvalid; i_rvalid stays 0.
- Assert rst while in WAIT_D, then mem_rvalid pulses after rst deasserts -> outputs 0 during rst; no d_rvalid; FSM in IDLE; next i_req granted normally.
- mem_rvalid pulse while in IDLE with no requests -> no i_rvalid or d_rvalid; state unchanged.
